// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: AES InvMixColumns over a 128-bit state, one column per cycle on a shared datapath
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [1:0]    col;
  logic [127:0]  work;
  logic [6:0]    base;
  logic [31:0]   c_in, c_out;
  logic [7:0]    s0, s1, s2, s3;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction
  // column 0 sits in the top 32 bits, so the slice base counts down with col
  assign base = {~col, 5'd0};
  assign c_in = work[base +: 32];
  assign {s0, s1, s2, s3} = c_in;
  assign c_out = {me(s0) ^ mb(s1) ^ md(s2) ^ m9(s3),
                  m9(s0) ^ me(s1) ^ mb(s2) ^ md(s3),
                  md(s0) ^ m9(s1) ^ me(s2) ^ mb(s3),
                  mb(s0) ^ md(s1) ^ m9(s2) ^ me(s3)};
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign state_out = work;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= 2'd0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= state_in;
          col   <= 2'd0;
          state <= BUSY;
        end
        BUSY: begin
          work[base +: 32] <= c_out;
          col              <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: scoreboard bench for inv_mix_columns_seq with directed vectors and random traffic
module tb_inv_mix_columns_seq;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] state_in, state_out;
  int           checks = 0, errors = 0;
  int           m_st = 0, m_cnt = 0, cyc = 0, acc_last = 0, acc_prev = 0, rdy_mode = 0;
  logic         hand_valid;
  logic [127:0] hand_exp;
  logic [127:0] q[$], iq[$];

  localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] COL_IN   = 128'h8e4da1bcd5d5d7d601010101c6c6c6c6;
  localparam logic [127:0] COL_OUT  = 128'hdb135345d4d4d4d501010101c6c6c6c6;

  inv_mix_columns_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input bit inv);
    logic [7:0]   co[4];
    logic [127:0] r = '0;
    logic [7:0]   acc;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gm(co[(k - rw + 4) % 4], s[127 - 8 * (4 * c + k) -: 8]);
        r[127 - 8 * (4 * c + rw) -: 8] = acc;
      end
    return r;
  endfunction

  // reference FSM and scoreboard queues, advanced on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= 0;
      m_cnt <= 0;
      q.delete();
      iq.delete();
    end else begin
      cyc <= cyc + 1;
      case (m_st)
        0: if (in_valid) begin
          q.push_back(hand_valid ? hand_exp : mixc(state_in, 1'b1));
          iq.push_back(state_in);
          acc_prev <= acc_last;
          acc_last <= cyc;
          m_st     <= 1;
          m_cnt    <= 0;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == 3) m_st <= 2;
        end
        default: if (out_ready) begin
          void'(q.pop_front());
          void'(iq.pop_front());
          m_st <= 0;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== {m_st == 0, m_st == 2, m_st != 0}) begin
      errors++;
      $display("FAIL ctrl: got ready/valid/busy=%b expected %b (t=%0t)",
               {in_ready, out_valid, busy}, {m_st == 0, m_st == 2, m_st != 0}, $time);
    end
    if (!rst_n) begin
      checks++;
      if (state_out !== '0) begin
        errors++;
        $display("FAIL reset_out: got %h expected 0", state_out);
      end
    end else if (m_st == 2) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL no_expect: output %h with empty scoreboard", state_out);
      end else begin
        if (state_out !== q[0]) begin
          errors++;
          $display("FAIL data: got %h expected %h", state_out, q[0]);
        end
        checks++;
        if (mixc(state_out, 1'b0) !== iq[0]) begin
          errors++;
          $display("FAIL roundtrip: mixcolumns(out)=%h expected input %h", mixc(state_out, 1'b0), iq[0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end

  task automatic send(input logic [127:0] d, input logic hv, input logic [127:0] he, input bit hold);
    int n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    state_in   = d;
    hand_valid = hv;
    hand_exp   = he;
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles", in_ready, n);
        break;
      end
      @(negedge clk);
    end
    if (!hold) begin
      @(negedge clk);
      in_valid   = 1'b0;
      hand_valid = 1'b0;
      state_in   = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 || m_st != 0) begin
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results still pending", q.size());
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; state_in = '0; hand_valid = 1'b0; hand_exp = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(FIPS_IN, 1'b1, FIPS_OUT, 1'b0);
    drain();
    send(COL_IN, 1'b1, COL_OUT, 1'b0);
    drain();
    rdy_mode = 2;
    send(COL_IN, 1'b1, COL_OUT, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    drain();
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      state_in = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    state_in = FIPS_IN;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = '0;
    checks++;
    if (acc_last - acc_prev != 6) begin
      errors++;
      $display("FAIL spacing: got %0d cycles between acceptances expected 6", acc_last - acc_prev);
    end
    drain();
    send(FIPS_IN, 1'b1, FIPS_OUT, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, state_out} !== {3'b100, 128'h0}) begin
      errors++;
      $display("FAIL reset_mid: got ready/valid/busy=%b out=%h expected 100 and 0",
               {in_ready, out_valid, busy}, state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(COL_IN, 1'b1, COL_OUT, 1'b0);
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, 1'b0);
    end
    rdy_mode = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_mix_columns_seq.md
INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL provide port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL provide port in_valid, input, 1 bit: state_in holds a block to transform.
REQ-006 The block SHALL provide port in_ready, output, 1 bit: the block can accept an input.
REQ-007 The block SHALL provide port state_in, input, 128 bits: AES state; byte k = bits [127-8k -: 8]; column c = bytes 4c..4c+3 (row 0 first).
REQ-008 The block SHALL provide port out_valid, output, 1 bit: state_out holds a finished result.
REQ-009 The block SHALL provide port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL provide port state_out, output, 128 bits: the InvMixColumns result, registered, same byte layout as state_in.
REQ-011 The block SHALL provide port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 For each column (s0..s3), the block SHALL compute over GF(2^8), polynomial 0x11B:
- s0' = e*s0 ^ b*s1 ^ d*s2 ^ 9*s3
- s1' = 9*s0 ^ e*s1 ^ b*s2 ^ d*s3
- s2' = d*s0 ^ 9*s1 ^ e*s2 ^ b*s3
- s3' = b*s0 ^ d*s1 ^ 9*s2 ^ e*s3
REQ-013 The block SHALL use exactly one column datapath: four multiply-by-e, b, d and 9 units each, shared over four cycles.
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-016 IDLE: on an edge with in_valid=1, the block SHALL do all of the following:
- load state_in into the working register;
- clear the 2-bit column counter col to 0;
- go to BUSY.
REQ-017 BUSY: on each edge, the block SHALL replace column col of the working register with its transformed value and increment col.
REQ-018 BUSY: on the edge that processes col=3, the block SHALL wrap col to 0 and go to DONE.
REQ-019 Latency SHALL be fixed: out_valid rises exactly 4 edges after the accepting edge.
REQ-020 DONE: state_out and out_valid SHALL hold stable until an edge with out_ready=1.
REQ-021 DONE: on that edge the block SHALL return to IDLE.
REQ-022 The earliest next acceptance SHALL be the following edge, giving a minimum of 6 cycles per block.
REQ-023 state_in SHALL be sampled only at the accepting edge; its later changes SHALL have no effect.
REQ-024 in_valid while BUSY or DONE SHALL be ignored and SHALL NOT be captured.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 state_out SHALL be driven directly from the working register; its value is defined only while out_valid=1.
REQ-027 col SHALL be 2 bits wide, and wrap from 3 to 0 SHALL be its only overflow.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL hold the following values:
- FSM = IDLE;
- col = 0;
- working register = 0;
- in_ready = 1 (combinational from IDLE);
- out_valid = 0;
- busy = 0;
- state_out = 0.
REQ-029 A reset asserted during BUSY or DONE SHALL discard the block in flight with no output.
REQ-030 After rst_n is released, the first rising edge SHALL be able to accept an input.

Verification
REQ-031 Bench scenario, FIPS-197 vector: state_in = 046681e5e0cb199a48f8d37a2806264c, in_valid for 1 cycle, out_ready=1 -> out_valid rises 4 edges later with state_out = d4bf5d30e0b452aeb84111f11e2798e5 for exactly 1 cycle.
REQ-032 Bench scenario, single-column identities: state_in = 8e4da1bc_d5d5d7d6_01010101_c6c6c6c6 -> state_out = db135345_d4d4d4d5_01010101_c6c6c6c6.
REQ-033 Bench scenario, backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and state_out stay stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-034 Bench scenario, ignored input: in_valid held high with state_in changing every cycle during BUSY -> result matches only the block accepted first; accepted blocks are spaced 6 cycles apart.
REQ-035 Bench scenario, reset mid-operation: rst_n pulsed low at BUSY col=2 -> out_valid=0, in_ready=1, state_out=0 immediately; a fresh vector after release produces a correct result.
REQ-036 Bench scenario, randomized: 1000 random states with random in_valid/out_ready gaps -> every output equals the software InvMixColumns result, and MixColumns applied to the output restores the input.
